// File: rtl/ravenoc_out_arbiter.sv
// Per-output-port wormhole switch allocator: round-robin among input ports,
// holding the grant from head flit to tail flit so packets never interleave.
module ravenoc_out_arbiter #(
    parameter int unsigned N_INPUTS = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [N_INPUTS-1:0]         req_i,
    input  logic [2*N_INPUTS-1:0]       flit_type_i,
    input  logic                        out_ready_i,
    output logic [N_INPUTS-1:0]         grant_o,
    output logic [$clog2(N_INPUTS)-1:0] sel_o,
    output logic                        out_valid_o,
    output logic                        busy_o,
    output logic                        err_o,
    output logic [CNT_W-1:0]            pkt_cnt_o
);

    localparam int unsigned SEL_W = $clog2(N_INPUTS);

    localparam logic [1:0] FT_HEAD      = 2'b00;
    localparam logic [1:0] FT_BODY      = 2'b01;
    localparam logic [1:0] FT_TAIL      = 2'b10;
    localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

    typedef enum logic [1:0] {StIdle, StHold, StLocked} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic               err_q, err_d;

    logic [1:0]          ft [N_INPUTS];
    logic [N_INPUTS-1:0] eligible;
    logic [N_INPUTS-1:0] bad_req;
    logic [SEL_W-1:0]    winner;
    logic [SEL_W-1:0]    idx;
    logic                found;
    logic [SEL_W-1:0]    sel;
    logic                valid;
    logic                has_grant;
    logic [1:0]          cur_ft;
    logic                xfer;
    logic                done;
    logic [SEL_W-1:0]    next_ptr;

    function automatic logic [SEL_W-1:0] rr_idx(logic [SEL_W-1:0] base, int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_INPUTS) sum = sum - N_INPUTS;
        return SEL_W'(sum);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            ft[i]       = flit_type_i[2*i +: 2];
            eligible[i] = req_i[i] & ((ft[i] == FT_HEAD) | (ft[i] == FT_HEAD_TAIL));
            bad_req[i]  = req_i[i] & ((ft[i] == FT_BODY) | (ft[i] == FT_TAIL));
        end
    end

    // First eligible input scanning upward from rr_ptr, with wrap.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < N_INPUTS; k++) begin
            idx = rr_idx(rr_ptr_q, k);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel       = owner_q;
        valid     = 1'b0;
        has_grant = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel       = winner;
                valid     = found;
                has_grant = found;
            end
            StHold: begin
                valid     = 1'b1;
                has_grant = 1'b1;
            end
            StLocked: begin
                valid     = req_i[owner_q];
                has_grant = 1'b1;
            end
            default: ;
        endcase
        cur_ft   = ft[sel];
        xfer     = valid & out_ready_i;
        next_ptr = (sel == SEL_W'(N_INPUTS - 1)) ? '0 : sel + SEL_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        pkt_cnt_d = pkt_cnt_q;
        err_d     = err_q;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bad_req) err_d = 1'b1;
                if (found) begin
                    if (!xfer) begin
                        owner_d = winner;
                        state_d = StHold;
                    end else if (cur_ft == FT_HEAD_TAIL) begin
                        done = 1'b1;
                    end else begin
                        owner_d = winner;
                        state_d = StLocked;
                    end
                end
            end
            StHold: begin
                if (xfer) begin
                    if (cur_ft == FT_HEAD_TAIL) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (xfer) begin
                    if (cur_ft == FT_TAIL) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else if (cur_ft != FT_BODY) begin
                        // A head inside a packet is a protocol error; it still moves as body.
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (done) begin
            rr_ptr_d  = next_ptr;
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            pkt_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_q     <= err_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign grant_o     = (arst && has_grant) ? (N_INPUTS'(1) << sel) : '0;
    assign sel_o       = (arst && has_grant) ? sel : '0;
    assign out_valid_o = arst & valid;
    assign busy_o      = (state_q != StIdle);
    assign err_o       = err_q;
    assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_ravenoc_out_arbiter.sv
// Bench for ravenoc_out_arbiter: directed scenarios plus randomized packet
// traffic, all checked against a packet-level reference model.
module tb_ravenoc_out_arbiter;

    localparam int N  = 5;
    localparam int CW = 16;

    localparam logic [1:0] HD = 2'b00;
    localparam logic [1:0] BD = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] HT = 2'b11;

    logic           clk = 1'b0;
    logic           arst = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [2*N-1:0] flit_type_i = '0;
    logic           out_ready_i = 1'b0;
    logic [N-1:0]   grant_o;
    logic [2:0]     sel_o;
    logic           out_valid_o;
    logic           busy_o;
    logic           err_o;
    logic [CW-1:0]  pkt_cnt_o;

    always #5 clk = ~clk;

    ravenoc_out_arbiter #(.N_INPUTS(N), .CNT_W(CW)) dut (
        .clk         (clk),
        .arst        (arst),
        .req_i       (req_i),
        .flit_type_i (flit_type_i),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .sel_o       (sel_o),
        .out_valid_o (out_valid_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owner of the output (-1 = free), whether its head was accepted.
    int           m_owner;
    bit           m_locked;
    int           m_ptr;
    int           m_cnt;
    bit           m_err;
    logic [N-1:0] e_grant;
    int           e_sel;
    bit           e_valid;

    int           len [N];
    int           pos [N];
    logic [N-1:0] rq;
    logic [2*N-1:0] rft;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] tp(int i);
        return flit_type_i[2*i +: 2];
    endfunction

    function automatic logic [2*N-1:0] ft1(int i, logic [1:0] t);
        logic [2*N-1:0] v;
        v = '0;
        v[2*i +: 2] = t;
        return v;
    endfunction

    function automatic logic [1:0] seq3(int p);
        return (p == 0) ? HD : (p == 1) ? BD : TL;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_locked = 1'b0;
        m_ptr    = 0;
        m_cnt    = 0;
        m_err    = 1'b0;
    endtask

    task automatic complete(input int who);
        m_owner  = -1;
        m_locked = 1'b0;
        m_ptr    = (who + 1) % N;
        m_cnt++;
    endtask

    task automatic model_eval();
        e_grant = '0;
        e_sel   = 0;
        e_valid = 1'b0;
        if (!arst) return;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req_i[i] && (tp(i) == HD || tp(i) == HT)) begin
                    e_sel      = i;
                    e_valid    = 1'b1;
                    e_grant[i] = 1'b1;
                    break;
                end
            end
        end else begin
            e_sel            = m_owner;
            e_grant[m_owner] = 1'b1;
            e_valid          = m_locked ? req_i[m_owner] : 1'b1;
        end
    endtask

    task automatic model_step();
        bit         xfer;
        logic [1:0] t;
        if (!arst) return;
        xfer = e_valid && out_ready_i;
        t    = tp(e_sel);
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++)
                if (req_i[i] && (tp(i) == BD || tp(i) == TL)) m_err = 1'b1;
            if (e_valid) begin
                if (xfer && t == HT) complete(e_sel);
                else begin
                    m_owner  = e_sel;
                    m_locked = xfer;
                end
            end
        end else if (xfer) begin
            if (!m_locked) begin
                if (t == HT) complete(m_owner);
                else m_locked = 1'b1;
            end else if (t == TL) complete(m_owner);
            else if (t != BD) m_err = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("grant", 32'(grant_o), 32'(e_grant));
        check("sel", 32'(sel_o), e_sel);
        check("valid", 32'(out_valid_o), 32'(e_valid));
        check("busy", 32'(busy_o), 32'(arst && m_owner >= 0));
        check("err", 32'(err_o), 32'(m_err));
        check("cnt", 32'(pkt_cnt_o), m_cnt % (1 << CW));
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [2*N-1:0] ft, input logic rdy);
        @(negedge clk);
        req_i       = req;
        flit_type_i = ft;
        out_ready_i = rdy;
        #1;
        model_eval();
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    // Asserted mid-cycle with whatever request is currently presented.
    task automatic do_reset();
        @(negedge clk);
        arst = 1'b0;
        model_reset();
        #1;
        model_eval();
        compare_all();
        @(posedge clk);
        #1;
        arst = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single head-tail packet, zero-latency grant.
        drive(5'b00100, ft1(2, HT), 1'b1);
        check("t1_grant", 32'(grant_o), 32'h04);
        check("t1_sel", 32'(sel_o), 2);
        check("t1_valid", 32'(out_valid_o), 1);
        tick();
        drive('0, '0, 1'b1);
        check("t1_cnt", 32'(pkt_cnt_o), 1);
        check("t1_busy", 32'(busy_o), 0);
        tick();
        drive(5'b11111, {5{HT}}, 1'b1);
        check("t1_ptr", 32'(grant_o), 32'h08);
        tick();

        // All inputs streaming head-tail: strict rotation.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(5'b11111, {5{HT}}, 1'b1);
            check("t3_order", 32'(grant_o), 32'(1) << (c % 5));
            tick();
        end

        // Two concurrent 3-flit packets never interleave.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                drive(5'b01001, ft1(0, seq3(c)) | ft1(3, HD), 1'b1);
                check("t2_own0", 32'(grant_o), 32'h01);
            end else begin
                drive(5'b01000, ft1(3, seq3(c - 3)), 1'b1);
                check("t2_own3", 32'(grant_o), 32'h08);
            end
            tick();
        end
        drive('0, '0, 1'b1);
        check("t2_cnt", 32'(pkt_cnt_o), 2);
        tick();

        // HOLD keeps the offer stable while downstream stalls.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive((c >= 2) ? 5'b00011 : 5'b00010, '0, 1'b0);
            check("t4_hold", 32'(grant_o), 32'h02);
            tick();
        end
        drive(5'b00011, '0, 1'b1);
        check("t4_acc", 32'(grant_o), 32'h02);
        tick();
        drive(5'b00011, ft1(1, BD), 1'b1);
        check("t4_body", 32'(grant_o), 32'h02);
        tick();
        drive(5'b00011, ft1(1, TL), 1'b1);
        check("t4_tail", 32'(grant_o), 32'h02);
        tick();
        drive(5'b00001, '0, 1'b1);
        check("t4_next", 32'(grant_o), 32'h01);
        tick();

        // Owner drops its request mid-packet.
        do_reset();
        drive(5'b10000, ft1(4, HD), 1'b1);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(5'b01000, ft1(3, HD), 1'b1);
            check("t5_valid", 32'(out_valid_o), 0);
            check("t5_grant", 32'(grant_o), 32'h10);
            tick();
        end
        drive(5'b11000, ft1(4, TL) | ft1(3, HD), 1'b1);
        check("t5_tail", 32'(grant_o), 32'h10);
        tick();
        drive(5'b01000, ft1(3, HD), 1'b1);
        check("t5_next", 32'(grant_o), 32'h08);
        tick();

        // Protocol errors.
        do_reset();
        drive(5'b00100, ft1(2, BD), 1'b1);
        check("t6_nogrant", 32'(grant_o), 0);
        tick();
        drive('0, '0, 1'b1);
        check("t6_err", 32'(err_o), 1);
        tick();
        do_reset();
        drive(5'b00001, ft1(0, HD), 1'b1);
        tick();
        drive(5'b00001, ft1(0, HD), 1'b1);
        check("t6_lk_valid", 32'(out_valid_o), 1);
        tick();
        drive(5'b00001, ft1(0, TL), 1'b1);
        check("t6_lk_err", 32'(err_o), 1);
        check("t6_lk_busy", 32'(busy_o), 1);
        tick();
        drive('0, '0, 1'b1);
        check("t6_lk_cnt", 32'(pkt_cnt_o), 1);
        tick();

        // Reset in the middle of a packet.
        drive(5'b00010, ft1(1, HD), 1'b1);
        tick();
        drive(5'b00010, ft1(1, BD), 1'b1);
        tick();
        do_reset();
        check("t6_rst_err", 32'(err_o), 0);
        drive(5'b11111, {5{HT}}, 1'b1);
        check("t6_ptr0", 32'(grant_o), 32'h01);
        tick();

        // Randomized well-formed packet traffic.
        do_reset();
        rq = '0;
        for (int i = 0; i < N; i++) begin
            len[i] = $urandom_range(4, 1);
            pos[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rft = '0;
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(2, 0) != 0) rq[i] = 1'b1;
                rft[2*i +: 2] = (len[i] == 1) ? HT :
                                (pos[i] == 0) ? HD :
                                (pos[i] == len[i] - 1) ? TL : BD;
            end
            drive(rq, rft, $urandom_range(3, 0) != 0);
            tick();
            if (e_valid && out_ready_i) begin
                for (int i = 0; i < N; i++) begin
                    if (e_grant[i]) begin
                        rq[i] = 1'b0;
                        pos[i]++;
                        if (pos[i] == len[i]) begin
                            pos[i] = 0;
                            len[i] = $urandom_range(4, 1);
                        end
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ravenoc_out_arbiter.md
Name: ravenoc_out_arbiter

Overview:
Per-output-port wormhole switch allocator for a RaveNoC router. It arbitrates among the router's input ports (north, south, west, east, local) that want the same output port, using round-robin priority. A grant is held from head flit to tail flit so packets are never interleaved. The router instantiates one per output port; the granted index drives the output crossbar mux.

Parameters:
N_INPUTS, 5, number of competing input ports (index 0..N_INPUTS-1)
CNT_W, 16, width of the completed-packet counter

Ports:
clk  input  1  system clock
arst  input  1  reset, asynchronous, active-low
req_i  input  N_INPUTS  input i has a flit at its head targeting this output
flit_type_i  input  2*N_INPUTS  type of input i's head flit, bits [2i+1:2i]: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL (single-flit packet)
out_ready_i  input  1  downstream accepts a flit this cycle
grant_o  output  N_INPUTS  one-hot grant; also pops the granted input buffer when transfer occurs
sel_o  output  $clog2(N_INPUTS)  binary index of the granted input, for the crossbar mux
out_valid_o  output  1  flit presented downstream
busy_o  output  1  arbiter is in HOLD or LOCKED
err_o  output  1  sticky protocol-error flag
pkt_cnt_o  output  CNT_W  completed packets, wraps modulo 2^CNT_W

Behaviour:
- Transfer condition: xfer = out_valid_o & out_ready_i.
- Reset (arst low, asynchronous): state = IDLE, rr_ptr = 0, owner = 0, pkt_cnt_o = 0, err_o = 0. Outputs during reset: grant_o = 0, sel_o = 0, out_valid_o = 0, busy_o = 0. Reset mid-packet drops the lock with no partial flush.
- Eligibility in IDLE: input i is eligible iff req_i[i] and type is HEAD or HEAD_TAIL. BODY or TAIL requests in IDLE are ignored and set err_o.
- Winner selection: combinational, zero latency. The winner is the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo N_INPUTS.
- State IDLE:
  - If no input is eligible: grant_o = 0, out_valid_o = 0.
  - Otherwise grant_o = onehot(winner), sel_o = winner, out_valid_o = 1.
  - xfer on HEAD_TAIL: stay IDLE, rr_ptr = winner+1 (wraps), pkt_cnt +1.
  - xfer on HEAD: owner = winner, go to LOCKED.
  - No xfer (out_ready_i low): owner = winner, go to HOLD. This keeps the offer stable; out_valid_o never drops before acceptance.
- State HOLD:
  - grant_o = onehot(owner), out_valid_o = 1. Upstream must keep req and type stable.
  - xfer on HEAD_TAIL: go to IDLE, rr_ptr = owner+1, pkt_cnt +1.
  - xfer on HEAD: go to LOCKED.
- State LOCKED:
  - grant_o = onehot(owner) whether or not req_i[owner] is asserted; out_valid_o = req_i[owner].
  - Requests from other inputs are ignored.
  - xfer on BODY: stay LOCKED.
  - xfer on TAIL: go to IDLE, rr_ptr = owner+1, pkt_cnt +1.
  - xfer on HEAD or HEAD_TAIL: set err_o, treat the flit as BODY, stay LOCKED.
- busy_o = (state != IDLE).
- err_o is sticky; only reset clears it.
- Round-robin pointer:
  - rr_ptr advances only on packet completion, never on a head flit alone. This gives fairness per packet, not per flit.
  - Wrap: owner = N_INPUTS-1 gives rr_ptr = 0.
- Latency: grant is combinational in the same cycle as req in IDLE. The first flit can move in the cycle its request appears; back-to-back packets from different inputs need no bubble cycle.
- Simultaneous events: a tail xfer and a new head request in the same cycle resolve as tail completes and state returns to IDLE. The new head is arbitrated next cycle against the updated rr_ptr.
- Counter wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Single HEAD_TAIL on input 2, out_ready_i = 1, after reset -> grant_o = 00100, sel_o = 2, out_valid_o = 1 in the same cycle; next cycle rr_ptr = 3, pkt_cnt_o = 1, busy_o = 0.
- Inputs 0 and 3 both send 3-flit packets (HEAD, BODY, TAIL) concurrently with ready held high -> input 0 owns for 3 xfers, then input 3 for 3 xfers; grant_o never changes mid-packet; pkt_cnt_o = 2.
- All 5 inputs request HEAD_TAIL continuously for 10 cycles -> grant order 0,1,2,3,4,0,1,2,3,4.
- HEAD on input 1 with out_ready_i low for 4 cycles, and input 0 raising HEAD in cycle 2 -> HOLD with grant_o = 00010 held stable; input 1 is accepted when ready rises; input 0 waits until input 1's TAIL completes.
- LOCKED on input 4 with req_i[4] dropping for 2 cycles mid-packet -> out_valid_o = 0 while grant_o = 10000 is held; input 3's pending HEAD is not granted.
- Protocol errors: BODY on input 2 in IDLE -> err_o = 1, no grant. Separately, HEAD from the owner while LOCKED -> err_o = 1, flit transferred as BODY. Pulse arst low mid-packet -> all outputs 0, state IDLE, rr_ptr = 0, err_o = 0.
